// File: rtl/sequencia_multi.sv
// Serial multi-pattern detector: shifts a gated bit stream through a W-bit window and
// compares it against N_PAT masked patterns, with sticky flags and a saturating match count.
module sequencia_multi #(
  parameter  int W     = 8,
  parameter  int N_PAT = 4,
  parameter  int CNT_W = 8,
  localparam int IW    = (N_PAT > 1) ? $clog2(N_PAT) : 1,
  localparam int FW    = $clog2(W)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_we_i,
  input  logic [IW-1:0]    cfg_idx_i,
  input  logic [W-1:0]     cfg_pattern_i,
  input  logic [W-1:0]     cfg_mask_i,
  input  logic             overlap_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             bit_valid_i,
  input  logic             bit_in_i,
  output logic [N_PAT-1:0] match_pulse_o,
  output logic             match_any_o,
  output logic [N_PAT-1:0] found_o,
  output logic [CNT_W-1:0] match_count_o,
  output logic             busy_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FILL   = 2'd1;
  localparam logic [1:0] SEARCH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [W-1:0]     win_q, win_d;
  logic [W-1:0]     pat_q  [N_PAT];
  logic [W-1:0]     mask_q [N_PAT];
  logic [N_PAT-1:0] pulse_q, pulse_d;
  logic [N_PAT-1:0] found_q, found_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [W-1:0]     win_nx;
  logic [N_PAT-1:0] hit;
  logic             accept, last_fill, cmp_en, any_hit;

  always_comb begin
    win_nx    = {win_q[W-2:0], bit_in_i};
    // start/stop take priority, so a bit arriving alongside them is dropped
    accept    = bit_valid_i & ~start_i & ~stop_i & (state_q != IDLE);
    last_fill = (state_q == FILL) && (fill_q == FW'(W - 1));
    cmp_en    = accept & ((state_q == SEARCH) | last_fill);
    for (int i = 0; i < N_PAT; i++) begin
      hit[i] = cmp_en & (|mask_q[i]) & (((win_nx ^ pat_q[i]) & mask_q[i]) == '0);
    end
    any_hit = |hit;

    state_d = state_q;
    fill_d  = fill_q;
    win_d   = win_q;
    pulse_d = hit;
    found_d = found_q | hit;
    cnt_d   = cnt_q;
    if (any_hit && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);

    if (start_i) begin
      state_d = FILL;
      fill_d  = '0;
      win_d   = '0;
      found_d = '0;
      cnt_d   = '0;
    end else if (stop_i) begin
      state_d = IDLE;
    end else if (accept) begin
      win_d = win_nx;
      // non-overlapping search restarts the fill; old window bits are never compared again
      if (any_hit && !overlap_i) begin
        state_d = FILL;
        fill_d  = '0;
      end else if (last_fill) begin
        state_d = SEARCH;
      end else if (state_q == FILL) begin
        fill_d = fill_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      fill_q  <= '0;
      win_q   <= '0;
      pulse_q <= '0;
      found_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < N_PAT; i++) begin
        pat_q[i]  <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      win_q   <= win_d;
      pulse_q <= pulse_d;
      found_q <= found_d;
      cnt_q   <= cnt_d;
      // slot writes land after this edge's compare, which used the old contents
      for (int i = 0; i < N_PAT; i++) begin
        if (cfg_we_i && (cfg_idx_i == IW'(i))) begin
          pat_q[i]  <= cfg_pattern_i;
          mask_q[i] <= cfg_mask_i;
        end
      end
    end
  end

  assign match_pulse_o = pulse_q;
  assign match_any_o   = |pulse_q;
  assign found_o       = found_q;
  assign match_count_o = cnt_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_sequencia_multi.sv
// Directed bench for sequencia_multi: a vector table for the basic match path plus
// hand-written sequences for overlap, masking, saturation and control corner cases.
module tb_sequencia_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [7:0] cfg_pattern = '0;
  logic [7:0] cfg_mask = '0;
  logic       overlap = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;

  logic [3:0] pulse_a, found_a, pulse_b, found_b;
  logic       any_a, any_b, busy_a, busy_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sequencia_multi #(.W(8), .N_PAT(4), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
    .cfg_pattern_i(cfg_pattern), .cfg_mask_i(cfg_mask), .overlap_i(overlap),
    .start_i(start), .stop_i(stop), .bit_valid_i(bit_valid), .bit_in_i(bit_in),
    .match_pulse_o(pulse_a), .match_any_o(any_a), .found_o(found_a),
    .match_count_o(cnt_a), .busy_o(busy_a)
  );

  sequencia_multi #(.W(8), .N_PAT(4), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
    .cfg_pattern_i(cfg_pattern), .cfg_mask_i(cfg_mask), .overlap_i(overlap),
    .start_i(start), .stop_i(stop), .bit_valid_i(bit_valid), .bit_in_i(bit_in),
    .match_pulse_o(pulse_b), .match_any_o(any_b), .found_o(found_b),
    .match_count_o(cnt_b), .busy_o(busy_b)
  );

  typedef struct packed {
    logic       st;
    logic       sp;
    logic       v;
    logic       b;
    logic [3:0] pulse;
    logic [3:0] found;
    logic [7:0] cnt;
    logic       busy;
  } vec_t;

  vec_t tv [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // apply one cycle of control/bit inputs, sample 1 time unit after the edge
  task automatic cyc(input logic s, input logic p, input logic v, input logic b);
    start = s; stop = p; bit_valid = v; bit_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [7:0] pat, input logic [7:0] msk);
    cfg_we = 1'b1; cfg_idx = idx; cfg_pattern = pat; cfg_mask = msk;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cfg_we = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) cyc(1'b0, 1'b0, 1'b1, d[i]);
  endtask

  initial begin
    logic [7:0] d;

    // 1: reset, then bits with no start
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_pulse", 32'(pulse_a), 32'h0);
    chk("rst_any", 32'(any_a), 32'h0);
    chk("rst_found", 32'(found_a), 32'h0);
    chk("rst_count", 32'(cnt_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    rst = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h00);
    chk("idle_pulse", 32'(pulse_a), 32'h0);
    chk("idle_found", 32'(found_a), 32'h0);
    chk("idle_count", 32'(cnt_a), 32'h0);
    chk("idle_busy", 32'(busy_a), 32'h0);

    // 2: table-driven A5 match with an idle cycle mid-stream
    cfg(2'd0, 8'hA5, 8'hFF);
    overlap = 1'b1;
    tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'd0, 1'b1};
    tv[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 8'd0, 1'b1};
    tv[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 8'd0, 1'b1};
    tv[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 8'd0, 1'b1};
    tv[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 8'd0, 1'b1};
    tv[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 8'd0, 1'b1};
    tv[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 8'd0, 1'b1};
    tv[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 8'd0, 1'b1};
    tv[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 8'd0, 1'b1};
    tv[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 4'h1, 8'd1, 1'b1};
    tv[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h1, 8'd1, 1'b1};
    for (int k = 0; k < 11; k++) begin
      cyc(tv[k].st, tv[k].sp, tv[k].v, tv[k].b);
      chk($sformatf("tv%0d_pulse", k), 32'(pulse_a), 32'(tv[k].pulse));
      chk($sformatf("tv%0d_any", k), 32'(any_a), 32'(|tv[k].pulse));
      chk($sformatf("tv%0d_found", k), 32'(found_a), 32'(tv[k].found));
      chk($sformatf("tv%0d_count", k), 32'(cnt_a), 32'(tv[k].cnt));
      chk($sformatf("tv%0d_busy", k), 32'(busy_a), 32'(tv[k].busy));
    end

    // 3: overlapping vs non-overlapping on AA,1,0
    cfg(2'd0, 8'hAA, 8'hFF);
    overlap = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'hAA);
    chk("ov1_first", 32'(pulse_a), 32'h1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("ov1_mid", 32'(pulse_a), 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ov1_second", 32'(pulse_a), 32'h1);
    chk("ov1_count", 32'(cnt_a), 32'd2);
    overlap = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'hAA);
    chk("ov0_first", 32'(pulse_a), 32'h1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ov0_second", 32'(pulse_a), 32'h0);
    chk("ov0_count", 32'(cnt_a), 32'd1);

    // 4: masked nibble match; zero mask disables a slot
    cfg(2'd1, 8'hF0, 8'hF0);
    cfg(2'd2, 8'h00, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'hF6);
    chk("mask_f6", 32'(pulse_a), 32'h2);
    send_byte(8'h00);
    chk("mask_off", 32'(pulse_a), 32'h0);
    chk("mask_found", 32'(found_a), 32'h2);

    // 5: two slots hit in the same cycle, count advances once
    cfg(2'd0, 8'h0F, 8'hFF);
    cfg(2'd3, 8'h0F, 8'h0F);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h0F);
    chk("multi_pulse", 32'(pulse_a), 32'h9);
    chk("multi_any", 32'(any_a), 32'h1);
    chk("multi_count", 32'(cnt_a), 32'd1);

    // 6: saturation, restart, stop, stop+start, cfg write during a bit
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int m = 0; m < 5; m++) send_byte(8'h0F);
    chk("sat_count_w8", 32'(cnt_a), 32'd5);
    chk("sat_count_w2", 32'(cnt_b), 32'd3);
    chk("sat_found_w2", 32'(found_b), 32'h9);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("stop_busy", 32'(busy_a), 32'h0);
    chk("stop_count_kept", 32'(cnt_a), 32'd5);
    chk("stop_found_kept", 32'(found_a), 32'h9);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("start_found", 32'(found_b), 32'h0);
    chk("start_count", 32'(cnt_b), 32'd0);
    chk("start_busy", 32'(busy_b), 32'h1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("stopstart_busy", 32'(busy_a), 32'h1);
    d = 8'h0F;
    for (int i = 7; i >= 1; i--) cyc(1'b0, 1'b0, 1'b1, d[i]);
    chk("dropped_bit", 32'(pulse_a), 32'h0);
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_pattern = 8'h00; cfg_mask = 8'hFF;
    cyc(1'b0, 1'b0, 1'b1, d[0]);
    cfg_we = 1'b0;
    chk("cfg_old_used", 32'(pulse_a), 32'h9);
    chk("cfg_count", 32'(cnt_a), 32'd1);
    send_byte(8'h00);
    chk("cfg_new_used", 32'(pulse_a), 32'h1);

    // reset mid-search clears everything
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    chk("rst2_busy", 32'(busy_a), 32'h0);
    chk("rst2_found", 32'(found_a), 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h00);
    chk("rst2_pat_lost", 32'(pulse_a), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
